// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes, operand
// forwarding selects, a RUN/HALTED/STEP debug FSM and saturating perf counters.
module hazard_controller #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Rs1_ID,
  input  logic [ADDR_WIDTH-1:0] Rs2_ID,
  input  logic                  uses_rs1_ID,
  input  logic                  uses_rs2_ID,
  input  logic [ADDR_WIDTH-1:0] Rs1_EX,
  input  logic [ADDR_WIDTH-1:0] Rs2_EX,
  input  logic [ADDR_WIDTH-1:0] Rd_EX,
  input  logic [ADDR_WIDTH-1:0] Rd_MEM,
  input  logic [ADDR_WIDTH-1:0] Rd_WB,
  input  logic                  MemRead_EX,
  input  logic                  RegWrite_MEM,
  input  logic                  RegWrite_WB,
  input  logic                  redirect_MEM,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  resume_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;

  state_t               state_q, state_d;
  logic                 halted_q;
  logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
  logic                 load_use, stall_applied;

  // MEM wins over WB so the youngest producer's value is used; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] rs,
                                         input logic rw_mem, input logic [ADDR_WIDTH-1:0] rd_mem,
                                         input logic rw_wb,  input logic [ADDR_WIDTH-1:0] rd_wb);
    if (rw_mem && rd_mem != '0 && rd_mem == rs)   return 2'b10;
    else if (rw_wb && rd_wb != '0 && rd_wb == rs) return 2'b01;
    else                                          return 2'b00;
  endfunction

  assign forward_a = fwd_sel(Rs1_EX, RegWrite_MEM, Rd_MEM, RegWrite_WB, Rd_WB);
  assign forward_b = fwd_sel(Rs2_EX, RegWrite_MEM, Rd_MEM, RegWrite_WB, Rd_WB);

  assign load_use = MemRead_EX && (Rd_EX != '0) &&
                    ((uses_rs1_ID && Rd_EX == Rs1_ID) || (uses_rs2_ID && Rd_EX == Rs2_ID));
  assign stall_applied = !redirect_MEM && load_use && (state_q != HALTED);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (redirect_MEM) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (stall_applied || state_q == HALTED) begin
      // Freeze fetch and inject bubbles so older instructions drain.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  if (resume_req) state_d = RUN;
               else if (step_req) state_d = STEP;
      STEP:    state_d = resume_req ? RUN : HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_applied && stall_q != '1) stall_d = stall_q + 1'b1;
    if (redirect_MEM && flush_q != '1)  flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: vector table for the combinational
// hazard/forwarding paths plus hand sequences for debug FSM, saturation and reset.
module tb_hazard_controller;
  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  Rs1_ID, Rs2_ID, Rs1_EX, Rs2_EX, Rd_EX, Rd_MEM, Rd_WB;
  logic        uses_rs1_ID, uses_rs2_ID, MemRead_EX, RegWrite_MEM, RegWrite_WB, redirect_MEM;
  logic        halt_req, step_req, resume_req;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] stall_count, flush_count;

  int checks = 0, errors = 0;
  logic [15:0] exp_stall = 0, exp_flush = 0;

  hazard_controller #(.ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
    .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .Rs1_EX(Rs1_EX), .Rs2_EX(Rs2_EX), .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .MemRead_EX(MemRead_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .redirect_MEM(redirect_MEM), .halt_req(halt_req), .step_req(step_req),
    .resume_req(resume_req), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .forward_a(forward_a), .forward_b(forward_b), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1_id, rs2_id; logic u1, u2;
    logic [4:0] rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic memread, rw_mem, rw_wb, redirect;
    logic [4:0] exp_ctrl;   // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}
    logic [1:0] exp_fa, exp_fb;
    logic       stall_inc, flush_inc;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [4:0] rs1_id, logic [4:0] rs2_id, logic u1, logic u2,
                              logic [4:0] rs1_ex, logic [4:0] rs2_ex, logic [4:0] rd_ex,
                              logic [4:0] rd_mem, logic [4:0] rd_wb, logic memread,
                              logic rw_mem, logic rw_wb, logic redirect, logic [4:0] ctrl,
                              logic [1:0] fa, logic [1:0] fb, logic si, logic fi);
    vec_t v;
    v.rs1_id = rs1_id; v.rs2_id = rs2_id; v.u1 = u1; v.u2 = u2;
    v.rs1_ex = rs1_ex; v.rs2_ex = rs2_ex; v.rd_ex = rd_ex; v.rd_mem = rd_mem; v.rd_wb = rd_wb;
    v.memread = memread; v.rw_mem = rw_mem; v.rw_wb = rw_wb; v.redirect = redirect;
    v.exp_ctrl = ctrl; v.exp_fa = fa; v.exp_fb = fb; v.stall_inc = si; v.flush_inc = fi;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ctrl();
    return {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  task automatic clear_in();
    {Rs1_ID, Rs2_ID, Rs1_EX, Rs2_EX, Rd_EX, Rd_MEM, Rd_WB} = '0;
    {uses_rs1_ID, uses_rs2_ID, MemRead_EX, RegWrite_MEM, RegWrite_WB, redirect_MEM} = '0;
    {halt_req, step_req, resume_req} = '0;
  endtask

  task automatic set_load_use();
    MemRead_EX = 1; Rd_EX = 5; Rs1_ID = 5; uses_rs1_ID = 1;
  endtask

  task automatic check_cnt(string tag);
    check({tag, "_stall_count"}, stall_count, exp_stall);
    check({tag, "_flush_count"}, flush_count, exp_flush);
  endtask

  initial begin
    //                  rs1id rs2id u1 u2 rs1ex rs2ex rdex rdmem rdwb mr rwm rww red ctrl     fa     fb    si fi
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 2'b00, 2'b00, 0, 0);
    vecs[1]  = mk(5, 0, 1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 5'b00010, 2'b00, 2'b00, 1, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11000, 2'b00, 2'b00, 0, 0);
    vecs[3]  = mk(7, 7, 0, 1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 5'b00010, 2'b00, 2'b00, 1, 0);
    vecs[4]  = mk(7, 2, 0, 1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 5'b11000, 2'b00, 2'b00, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 3, 0, 0, 3, 3, 0, 1, 1, 0, 5'b11000, 2'b10, 2'b00, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 3, 0, 0, 3, 3, 0, 0, 1, 0, 5'b11000, 2'b01, 2'b00, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 4, 4, 0, 4, 4, 0, 0, 1, 0, 5'b11000, 2'b01, 2'b01, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 2'b00, 2'b00, 0, 0);
    vecs[9]  = mk(5, 0, 1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 5'b11111, 2'b00, 2'b00, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 2'b00, 2'b00, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 1, 9, 0, 9, 2, 0, 1, 1, 0, 5'b11000, 2'b00, 2'b10, 0, 0);

    clear_in();
    #2;
    check("reset_halted", halted, 0);
    check_cnt("reset");
    check("reset_ctrl", ctrl(), 5'b11000);
    @(negedge clk); rst = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      Rs1_ID = vecs[i].rs1_id; Rs2_ID = vecs[i].rs2_id;
      uses_rs1_ID = vecs[i].u1; uses_rs2_ID = vecs[i].u2;
      Rs1_EX = vecs[i].rs1_ex; Rs2_EX = vecs[i].rs2_ex; Rd_EX = vecs[i].rd_ex;
      Rd_MEM = vecs[i].rd_mem; Rd_WB = vecs[i].rd_wb; MemRead_EX = vecs[i].memread;
      RegWrite_MEM = vecs[i].rw_mem; RegWrite_WB = vecs[i].rw_wb; redirect_MEM = vecs[i].redirect;
      #1;
      check($sformatf("vec%0d_ctrl", i), ctrl(), vecs[i].exp_ctrl);
      check($sformatf("vec%0d_fwd_a", i), forward_a, vecs[i].exp_fa);
      check($sformatf("vec%0d_fwd_b", i), forward_b, vecs[i].exp_fb);
      exp_stall += 16'(vecs[i].stall_inc);
      exp_flush += 16'(vecs[i].flush_inc);
      @(posedge clk); #1;
      check_cnt($sformatf("vec%0d", i));
    end

    // Debug: halt, idle in HALTED, single step, step blocked by load-use, resume from STEP.
    @(negedge clk); clear_in(); halt_req = 1;
    @(posedge clk); #1;
    check("halt_halted", halted, 1);
    check("halt_ctrl", ctrl(), 5'b00010);
    @(negedge clk); halt_req = 0;
    @(posedge clk); #1;
    check("halt_hold", halted, 1);
    @(negedge clk); step_req = 1;
    @(posedge clk); #1;
    check("step_halted", halted, 0);
    check("step_pc_en", pc_en, 1);
    @(negedge clk); step_req = 0; halt_req = 1;   // halt ignored in STEP
    @(posedge clk); #1;
    check("step_done_halted", halted, 1);
    check("step_done_pc_en", pc_en, 0);
    @(negedge clk); halt_req = 0; step_req = 1;
    @(posedge clk); #1;
    @(negedge clk); step_req = 0; set_load_use(); #1;
    check("step_lu_ctrl", ctrl(), 5'b00010);
    exp_stall++;
    @(posedge clk); #1;
    check("step_lu_halted", halted, 1);
    check("step_lu_stall", stall_count, exp_stall);
    @(negedge clk); clear_in(); redirect_MEM = 1; #1;
    check("halted_redirect_ctrl", ctrl(), 5'b11111);
    exp_flush++;
    @(posedge clk); #1;
    check_cnt("halted_redirect");
    @(negedge clk); clear_in(); step_req = 1;
    @(posedge clk); #1;
    @(negedge clk); step_req = 0; resume_req = 1;
    @(posedge clk); #1;
    check("step_resume_halted", halted, 0);
    @(negedge clk); resume_req = 0; #1;
    check("run_ctrl", ctrl(), 5'b11000);
    @(posedge clk); #1;
    check("run_still", halted, 0);

    // Saturation: 2^16+3 consecutive load-use stall cycles.
    @(negedge clk); set_load_use();
    repeat (65539) @(posedge clk);
    #1;
    exp_stall = 16'hFFFF;
    check_cnt("sat");
    @(posedge clk); #1;
    check("sat_hold", stall_count, 16'hFFFF);

    // Asynchronous reset while HALTED, between clock edges.
    @(negedge clk); clear_in(); halt_req = 1;
    @(posedge clk); #1;
    check("pre_rst_halted", halted, 1);
    @(negedge clk); halt_req = 0; #2;
    rst = 1; #1;
    exp_stall = 0; exp_flush = 0;
    check("async_rst_halted", halted, 0);
    check_cnt("async_rst");
    @(negedge clk); rst = 0; #1;
    check("post_rst_ctrl", ctrl(), 5'b11000);
    @(negedge clk); set_load_use(); #1;
    check("post_rst_lu_ctrl", ctrl(), 5'b00010);
    exp_stall = 1;
    @(posedge clk); #1;
    check_cnt("post_rst");
    check("post_rst_halted", halted, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
